// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter between the motion controller (0)
// and an auxiliary monitor (1); includes a conversion timeout.
module a2d_arbiter #(
  parameter logic [9:0] TIMEOUT = 10'd600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [2:0]  chnl0,
  input  logic        req1,
  input  logic [2:0]  chnl1,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] res,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t     state;
  logic [9:0] cnt;
  logic       last;
  logic       winner;
  logic       pick;

  // On a tie the requester not granted last time wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last;
  end

  // Outputs are registered on the transition into the state that owns them,
  // so strt_cnv lines up with START and done0/done1 with DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      winner   <= 1'b0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      res      <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner   <= pick;
            chnnl    <= pick ? chnl1 : chnl0;
            strt_cnv <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 10'd1;
          if (cnv_cmplt) begin
            res   <= A2D_res;
            err   <= 1'b0;
            done0 <= ~winner;
            done1 <= winner;
            state <= DONE;
          end else if (cnt == TIMEOUT - 10'd1) begin
            // Counter starts at 0 on WAIT entry, so this is the TIMEOUT-th WAIT cycle.
            err   <= 1'b1;
            done0 <= ~winner;
            done1 <= winner;
            state <= DONE;
          end
        end
        DONE: begin
          last  <= winner;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
